// File: rtl/coproc_spi_master.sv
// coproc_spi_master: mode-0, MSB-first SPI master with one DATA_W-bit word per
// NSS frame. A word is accepted on i_tx_valid/o_tx_ready. The word shifted in
// on MISO is returned on o_rx_data with a one-cycle o_rx_valid pulse.
//
// Optional feature macro: COPROC_SPI_MASTER_BURST_EN
//   When defined, a new word offered on the final HOLD cycle is chained into
//   the same NSS frame with no GAP.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_clr       asynchronous active-high reset
//   i_tx_data   word to transmit, sampled only at the handshake
//   i_tx_valid  i_tx_data valid
//   o_tx_ready  master can accept a word (decoded from state)
//   o_rx_data   last received word, held until the next o_rx_valid
//   o_rx_valid  one-cycle pulse when o_rx_data updates
//   o_busy      high whenever the FSM is not IDLE
//   o_sclk      SPI clock, idle low
//   o_mosi      SPI data out
//   o_nss       SPI select, active low
//   i_miso      SPI data in
module coproc_spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_nss,
  input  logic              i_miso
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef COPROC_SPI_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              high_q, high_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              nss_q, nss_d;

  logic              cnt_last_c;
  logic              hold_ready_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [DATA_W-1:0] shift_in_c;

  // Shared half-period counter and the MISO shift-in value
  assign cnt_last_c   = (cnt_q == CNT_LAST);
  assign cnt_inc_c    = cnt_q + CNT_W'(1);
  assign shift_in_c   = {shreg_q[DATA_W-2:0], i_miso};
  assign hold_ready_c = BURST_EN && (state_q == HOLD) && cnt_last_c;

  assign o_tx_ready = (state_q == IDLE) || hold_ready_c;
  assign o_busy     = (state_q != IDLE);
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_sclk     = sclk_q;
  assign o_mosi     = mosi_q;
  assign o_nss      = nss_q;

  // State and output registers
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      high_q     <= 1'b0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      nss_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      high_q     <= high_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      nss_q      <= nss_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    high_d     = high_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    nss_d      = nss_q;

    case (state_q)
      IDLE: begin
        if (i_tx_valid) begin
          state_d = SETUP;
          shreg_d = i_tx_data;
          mosi_d  = i_tx_data[DATA_W-1];
          nss_d   = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      SETUP: begin
        if (cnt_last_c) begin
          // First rising SCLK edge; MISO is captured on the same edge
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          high_d  = 1'b1;
          sclk_d  = 1'b1;
          shreg_d = shift_in_c;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      SHIFT: begin
        if (!cnt_last_c) begin
          cnt_d = cnt_inc_c;
        end else begin
          cnt_d = '0;
          if (high_q) begin
            // Falling edge: after the shift the next TX bit sits in the MSB.
            // The last bit stays on MOSI through HOLD.
            high_d = 1'b0;
            sclk_d = 1'b0;
            if (bit_q != BIT_LAST) begin
              mosi_d = shreg_q[DATA_W-1];
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            high_d  = 1'b1;
            sclk_d  = 1'b1;
            shreg_d = shift_in_c;
          end
        end
      end

      HOLD: begin
        if (!cnt_last_c) begin
          cnt_d = cnt_inc_c;
        end else begin
          cnt_d      = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = shreg_q;
          if (hold_ready_c && i_tx_valid) begin
            // Chain the next word into the same frame; NSS stays low
            state_d = SETUP;
            shreg_d = i_tx_data;
            mosi_d  = i_tx_data[DATA_W-1];
          end else begin
            state_d = GAP;
            nss_d   = 1'b1;
          end
        end
      end

      GAP: begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coproc_spi_master.sv
// Self-checking bench for coproc_spi_master. Two instances are used:
// A (DATA_W=8, CLK_DIV=2) and B (DATA_W=16, CLK_DIV=1). Expected words and
// timings come from frame arithmetic. Bus monitors sample on the falling clock.
module tb_coproc_spi_master;

  localparam int unsigned AW = 8;
  localparam int unsigned AC = 2;
  localparam int unsigned BW = 16;
  localparam int unsigned BC = 1;
  localparam int A_NSS = (2*AW + 2) * AC;   // NSS low cycles per word
  localparam int A_LAT = A_NSS + 1;         // accept to rx_valid
  localparam int A_SPACE = (2*AW + 3) * AC + 1;
  localparam int B_NSS = (2*BW + 2) * BC;
  localparam int B_LAT = B_NSS + 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  // ---------------- instance A ----------------
  logic [AW-1:0] a_txd = '0;
  logic          a_txv = 1'b0;
  logic          a_rdy, a_rxv, a_busy, a_sclk, a_mosi, a_nss, a_miso;
  logic [AW-1:0] a_rxd;
  logic          a_loop = 1'b1;
  logic [AW-1:0] a_slave = '0;
  int            a_falls = 0;

  // Slave model: presents slave word MSB first, advancing on each SCLK fall
  always_comb begin
    if (a_loop)           a_miso = a_mosi;
    else if (a_falls < AW) a_miso = a_slave[AW-1-a_falls];
    else                  a_miso = 1'b0;
  end

  coproc_spi_master #(.DATA_W(AW), .CLK_DIV(AC)) u_a (
    .i_clk(clk), .i_clr(clr), .i_tx_data(a_txd), .i_tx_valid(a_txv),
    .o_tx_ready(a_rdy), .o_rx_data(a_rxd), .o_rx_valid(a_rxv), .o_busy(a_busy),
    .o_sclk(a_sclk), .o_mosi(a_mosi), .o_nss(a_nss), .i_miso(a_miso)
  );

  int a_rises = 0, a_stray = 0, a_nss_len = 0, a_last_nss = 0, a_nss_hi = 0;
  int a_last_gap = 0, a_frames = 0, a_accepts = 0, a_acc_cyc = 0, a_prev_acc = 0;
  int a_rxv_cyc = 0, a_rdy_busy = 0;
  logic a_psclk = 1'b0, a_pnss = 1'b1;
  logic [AW-1:0] a_rxq[$];
  logic a_mosiq[$];

  // ---------------- instance B ----------------
  logic [BW-1:0] b_txd = '0;
  logic          b_txv = 1'b0;
  logic          b_rdy, b_rxv, b_busy, b_sclk, b_mosi, b_nss;
  logic [BW-1:0] b_rxd;

  coproc_spi_master #(.DATA_W(BW), .CLK_DIV(BC)) u_b (
    .i_clk(clk), .i_clr(clr), .i_tx_data(b_txd), .i_tx_valid(b_txv),
    .o_tx_ready(b_rdy), .o_rx_data(b_rxd), .o_rx_valid(b_rxv), .o_busy(b_busy),
    .o_sclk(b_sclk), .o_mosi(b_mosi), .o_nss(b_nss), .i_miso(b_mosi)
  );

  int b_rises = 0, b_nss_len = 0, b_last_nss = 0, b_acc_cyc = 0, b_rxv_cyc = 0;
  logic b_psclk = 1'b0, b_pnss = 1'b1;
  logic [BW-1:0] b_rxq[$];

  // Bus monitors
  always @(negedge clk) begin
    cyc++;
    if (a_sclk && !a_psclk) begin
      a_rises++;
      a_mosiq.push_back(a_mosi);
      if (a_nss) a_stray++;
    end
    if (!a_sclk && a_psclk) a_falls++;
    if (a_nss) a_falls = 0;
    if (!a_nss) begin
      if (a_pnss) a_last_gap = a_nss_hi;
      a_nss_hi = 0;
      a_nss_len++;
    end else begin
      if (!a_pnss) begin
        a_last_nss = a_nss_len;
        a_frames++;
      end
      a_nss_len = 0;
      a_nss_hi++;
    end
    if (a_rxv) begin
      a_rxq.push_back(a_rxd);
      a_rxv_cyc = cyc;
    end
    if (a_txv && a_rdy && !clr) begin
      a_accepts++;
      a_prev_acc = a_acc_cyc;
      a_acc_cyc  = cyc;
    end
    if (a_busy && a_rdy) a_rdy_busy++;
    a_psclk = a_sclk;
    a_pnss  = a_nss;

    if (b_sclk && !b_psclk) b_rises++;
    if (!b_nss) b_nss_len++;
    else begin
      if (!b_pnss) b_last_nss = b_nss_len;
      b_nss_len = 0;
    end
    if (b_rxv) begin
      b_rxq.push_back(b_rxd);
      b_rxv_cyc = cyc;
    end
    if (b_txv && b_rdy && !clr) b_acc_cyc = cyc;
    b_psclk = b_sclk;
    b_pnss  = b_nss;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One framed word on A; expected RX is the TX word in loopback, else the slave word
  task automatic a_xfer(input logic [AW-1:0] w, input logic loop, input logic [AW-1:0] sw);
    int n;
    logic [31:0] mw;
    a_loop  = loop;
    a_slave = sw;
    a_rises = 0;
    a_mosiq.delete();
    a_rxq.delete();
    a_txd = w;
    a_txv = 1'b1;
    n = 0;
    while (!a_rdy && n < 500) begin tick(); n++; end
    tick();
    a_txv = 1'b0;
    a_txd = AW'($urandom);
    n = 0;
    while (a_rxq.size() == 0 && n < 500) begin tick(); n++; end
    chk("a_rx_data", (a_rxq.size() > 0) ? 32'(a_rxq[0]) : 32'hdead_beef,
        loop ? 32'(w) : 32'(sw));
    chk("a_latency", 32'(a_rxv_cyc - a_acc_cyc), 32'(A_LAT));
    chk("a_nss_low", 32'(a_last_nss), 32'(A_NSS));
    chk("a_rises", 32'(a_rises), 32'(AW));
    mw = '0;
    foreach (a_mosiq[i]) mw = {mw[30:0], a_mosiq[i]};
    chk("a_mosi_bits", mw, 32'(w));
  endtask

  task automatic b_xfer(input logic [BW-1:0] w);
    int n;
    b_rises = 0;
    b_rxq.delete();
    b_txd = w;
    b_txv = 1'b1;
    n = 0;
    while (!b_rdy && n < 500) begin tick(); n++; end
    tick();
    b_txv = 1'b0;
    b_txd = BW'($urandom);
    n = 0;
    while (b_rxq.size() == 0 && n < 500) begin tick(); n++; end
    chk("b_rx_data", (b_rxq.size() > 0) ? 32'(b_rxq[0]) : 32'hdead_beef, 32'(w));
    chk("b_latency", 32'(b_rxv_cyc - b_acc_cyc), 32'(B_LAT));
    chk("b_nss_low", 32'(b_last_nss), 32'(B_NSS));
    chk("b_rises", 32'(b_rises), 32'(BW));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int acc0;
    int fr0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    tick();
    chk("rst_nss", a_nss, 1'b1);
    chk("rst_sclk", a_sclk, 1'b0);
    chk("rst_mosi", a_mosi, 1'b0);
    chk("rst_rx_data", a_rxd, '0);
    chk("rst_rx_valid", a_rxv, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_tx_ready", a_rdy, 1'b1);
    chk("rst_b_nss", b_nss, 1'b1);

    // Loopback and slave-driven words
    a_xfer(8'hA5, 1'b1, 8'h00);
    repeat (20) tick();
    chk("a_rx_hold", a_rxd, 8'hA5);
    a_xfer(8'hFF, 1'b0, 8'h3C);

`ifndef COPROC_SPI_MASTER_BURST_EN
    // i_tx_valid held high: one accept per frame, GAP between frames
    repeat (5) tick();
    a_loop = 1'b1;
    a_rxq.delete();
    acc0 = a_accepts;
    a_txd = 8'h01;
    a_txv = 1'b1;
    n = 0;
    while (a_accepts == acc0 && n < 200) begin tick(); n++; end
    a_txd = 8'h02;
    n = 0;
    while (a_rxq.size() < 2 && n < 300) begin tick(); n++; end
    a_txv = 1'b0;
    repeat (50) tick();
    chk("hv_accepts", 32'(a_accepts - acc0), 32'd2);
    chk("hv_rx0", (a_rxq.size() > 0) ? 32'(a_rxq[0]) : 32'hdead_beef, 32'h01);
    chk("hv_rx1", (a_rxq.size() > 1) ? 32'(a_rxq[1]) : 32'hdead_beef, 32'h02);
    chk("hv_spacing", 32'(a_acc_cyc - a_prev_acc), 32'(A_SPACE));
    chk("hv_gap_ge2", 32'(a_last_gap >= 2), 32'd1);
    chk("hv_ready_busy", 32'(a_rdy_busy), 32'd0);
`else
    // Burst: two words in one NSS frame
    repeat (5) tick();
    a_loop = 1'b1;
    a_rxq.delete();
    a_rises = 0;
    acc0 = a_accepts;
    fr0 = a_frames;
    a_txd = 8'h11;
    a_txv = 1'b1;
    n = 0;
    while (a_accepts == acc0 && n < 200) begin tick(); n++; end
    a_txd = 8'h22;
    n = 0;
    while (a_rxq.size() < 1 && n < 300) begin tick(); n++; end
    a_txv = 1'b0;
    n = 0;
    while (a_rxq.size() < 2 && n < 300) begin tick(); n++; end
    repeat (20) tick();
    chk("bu_accepts", 32'(a_accepts - acc0), 32'd2);
    chk("bu_frames", 32'(a_frames - fr0), 32'd1);
    chk("bu_rx0", (a_rxq.size() > 0) ? 32'(a_rxq[0]) : 32'hdead_beef, 32'h11);
    chk("bu_rx1", (a_rxq.size() > 1) ? 32'(a_rxq[1]) : 32'hdead_beef, 32'h22);
    chk("bu_rises", 32'(a_rises), 32'd16);
    chk("bu_nss_low", 32'(a_last_nss), 32'(2 * A_NSS));
`endif

    // Reset after the third SCLK rise
    a_loop = 1'b1;
    a_rises = 0;
    a_txd = 8'h5A;
    a_txv = 1'b1;
    n = 0;
    while (!a_rdy && n < 200) begin tick(); n++; end
    tick();
    a_txv = 1'b0;
    n = 0;
    while (a_rises < 3 && n < 200) begin @(negedge clk); #1; n++; end
    chk("mr_reached", 32'(a_rises), 32'd3);
    a_rxq.delete();
    #1 clr = 1'b1;
    #1;
    chk("mr_nss", a_nss, 1'b1);
    chk("mr_sclk", a_sclk, 1'b0);
    chk("mr_busy", a_busy, 1'b0);
    chk("mr_rx_valid", a_rxv, 1'b0);
    repeat (3) tick();
    clr = 1'b0;
    repeat (60) tick();
    chk("mr_no_rx", 32'(a_rxq.size()), 32'd0);
    a_xfer(8'h5A, 1'b1, 8'h00);

    // Randomized words, loopback or slave-driven
    for (int i = 0; i < 10; i++) begin
      a_xfer(AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
    end
    chk("a_stray_rises", 32'(a_stray), 32'd0);

    // DATA_W=16, CLK_DIV=1 loopback
    b_xfer(16'h8001);
    for (int i = 0; i < 3; i++) b_xfer(BW'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
